// File: rtl/clken_synth_pkg.sv
// ---------------------------------------------------------------------------
// clken_synth_pkg
// Shared definitions for the fractional clock-enable synthesiser:
//   - state_e           : lock state machine encoding (SETTLE, LOCKED, RELOCK)
//   - DEFAULT_ACC_W     : default accumulator / increment width
//   - lock_cnt_width()  : width of the settle counter for a given LOCK_CYCLES
// ---------------------------------------------------------------------------
package clken_synth_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        RELOCK = 2'd2
    } state_e;

    localparam int DEFAULT_ACC_W = 32;

    // The counter only ever has to hold 0..LOCK_CYCLES-1. LOCK_CYCLES=1 still
    // needs a one-bit counter so the vector is never zero-width.
    function automatic int lock_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/clken_synth_acc.sv
// ---------------------------------------------------------------------------
// clken_acc
// One phase-accumulator channel. Produces a registered one-cycle enable pulse
// on every accumulator wrap and applies retuned increments only at a wrap so
// the pulse train stays phase-continuous.
// Ports:
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   en_i           : run enable; low holds the accumulator
//   cfg_inc_i      : new increment, captured into the shadow on cfg_load_i
//   cfg_load_i     : load strobe
//   ce_o           : registered enable pulse
//   pending_o      : shadow increment waiting to be applied (registered)
//   pending_next_o : next-state value of pending_o
// ---------------------------------------------------------------------------
module clken_acc
    import clken_synth_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] cfg_inc_i,
    input  logic             cfg_load_i,
    output logic             ce_o,
    output logic             pending_o,
    output logic             pending_next_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = sum[ACC_W];

    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        shd_d = shd_q;
        pend_d = pend_q;
        ce_d  = 1'b0;

        if (en_i) begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = carry;
        end

        // A load always wins over an apply on the same edge; the carry of that
        // edge still pulses with the old increment.
        if (cfg_load_i) begin
            shd_d  = cfg_inc_i;
            pend_d = 1'b1;
        end else if (pend_q && (!en_i || (inc_q == '0) || carry)) begin
            // A stalled or silent channel would never carry, so it takes the
            // new increment straight away instead of waiting for a wrap.
            inc_d  = shd_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q  <= '0;
            inc_q  <= '0;
            shd_q  <= '0;
            pend_q <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o           = ce_q;
    assign pending_o      = pend_q;
    assign pending_next_o = pend_d;

endmodule

// File: rtl/clken_synth.sv
// ---------------------------------------------------------------------------
// clken_synth
// Multi-channel fractional clock-enable synthesiser. Channel i pulses ce[i] at
// f_refclk * inc_i / 2^ACC_W. A settle state machine reports `locked` once all
// retuned increments are applied and LOCK_CYCLES quiet edges have elapsed.
// Ports:
//   refclk   : sole clock
//   rst      : asynchronous active-high reset
//   en       : per-channel run enable
//   cfg_inc  : packed new increments, channel i at [i*ACC_W +: ACC_W]
//   cfg_load : strobe capturing cfg_inc into every channel's shadow
//   ce       : registered one-cycle enable pulses
//   busy     : any channel has a pending increment
//   locked   : configuration applied and settled
// ---------------------------------------------------------------------------
module clken_synth
    import clken_synth_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int ACC_W       = DEFAULT_ACC_W,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       ce,
    output logic                    busy,
    output logic                    locked
);

    localparam int                CNT_W    = lock_cnt_width(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] pend_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clken_acc #(
                .ACC_W (ACC_W)
            ) u_acc (
                .clk_i          (refclk),
                .rst_i          (rst),
                .en_i           (en[gi]),
                .cfg_inc_i      (cfg_inc[gi*ACC_W +: ACC_W]),
                .cfg_load_i     (cfg_load),
                .ce_o           (ce[gi]),
                .pending_o      (pend_q[gi]),
                .pending_next_o (pend_next[gi])
            );
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        // Built from the channels' next pending state so busy lines up with
        // the pending registers themselves.
        busy_d   = |pend_next;

        if (cfg_load) begin
            state_d  = RELOCK;
            cnt_d    = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                SETTLE: begin
                    if (pend_q == '0) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    locked_d = 1'b1;
                end
                RELOCK: begin
                    // Leave on the edge the last pending bit clears so that
                    // lock follows exactly LOCK_CYCLES edges after it.
                    if (pend_next == '0) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d  = SETTLE;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            locked_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_clken_synth.sv
// ---------------------------------------------------------------------------
// tb_clken_synth
// Directed bench for clken_synth with NUM_CH=2, ACC_W=8, LOCK_CYCLES=16.
// A behavioural model tracks each channel's phase and the lock condition as
// "edges since configuration went quiet"; outputs are compared on every
// falling edge, and hand-computed literals pin key points of the model.
// ---------------------------------------------------------------------------
module tb_clken_synth;

    localparam int NCH  = 2;
    localparam int AW   = 8;
    localparam int LOCK = 16;
    localparam int MOD  = 1 << AW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    en = '0;
    logic [NCH*AW-1:0] cfg_inc = '0;
    logic              cfg_load = 1'b0;
    logic [NCH-1:0]    ce;
    logic              busy;
    logic              locked;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    clken_synth #(
        .NUM_CH      (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk   (clk),
        .rst      (rst),
        .en       (en),
        .cfg_inc  (cfg_inc),
        .cfg_load (cfg_load),
        .ce       (ce),
        .busy     (busy),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int       m_acc [NCH];
    int       m_inc [NCH];
    int       m_shd [NCH];
    bit       m_pend[NCH];
    bit [NCH-1:0] m_ce = '0;
    bit       m_busy = 1'b0;
    bit       m_locked = 1'b0;
    int       edge_n = 0;
    int       quiet_edge = 0;
    bit       quiet_valid = 1'b1;

    always @(posedge clk or posedge rst) begin
        int  sum;
        bit  carry;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c] = 0; m_inc[c] = 0; m_shd[c] = 0; m_pend[c] = 1'b0;
            end
            m_ce = '0; m_busy = 1'b0; m_locked = 1'b0;
            edge_n = 0; quiet_edge = 0; quiet_valid = 1'b1;
        end else begin
            edge_n++;
            for (int c = 0; c < NCH; c++) begin
                sum   = m_acc[c] + m_inc[c];
                carry = (sum >= MOD);
                if (en[c]) begin
                    m_acc[c] = sum % MOD;
                    m_ce[c]  = carry;
                end else begin
                    m_ce[c] = 1'b0;
                end
                if (cfg_load) begin
                    m_shd[c]  = int'(cfg_inc[c*AW +: AW]);
                    m_pend[c] = 1'b1;
                end else if (m_pend[c] && (!en[c] || m_inc[c] == 0 || carry)) begin
                    m_inc[c]  = m_shd[c];
                    m_pend[c] = 1'b0;
                end
            end
            m_busy = 1'b0;
            for (int c = 0; c < NCH; c++) m_busy |= m_pend[c];
            // Lock: LOCK edges after the moment nothing is pending, voided by any load.
            if (cfg_load) begin
                quiet_valid = 1'b0;
            end else if (!quiet_valid && !m_busy) begin
                quiet_valid = 1'b1;
                quiet_edge  = edge_n;
            end
            m_locked = quiet_valid && (edge_n - quiet_edge >= LOCK);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (ce !== m_ce || busy !== m_busy || locked !== m_locked) begin
                fails++;
                $display("FAIL model t=%0t: ce=%b busy=%b locked=%b, required ce=%b busy=%b locked=%b",
                         $time, ce, busy, locked, m_ce, m_busy, m_locked);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts pulses per channel over n observed cycles plus back-to-back ch0 pulses.
    task automatic count_ce(input int n, output int c0, output int c1, output int dbl0);
        bit prev0;
        c0 = 0; c1 = 0; dbl0 = 0; prev0 = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (ce[0] === 1'b1) c0++;
            if (ce[1] === 1'b1) c1++;
            if (prev0 && ce[0] === 1'b1) dbl0++;
            prev0 = (ce[0] === 1'b1);
        end
    endtask

    // Drives a one-cycle load; returns at the falling edge after the load edge.
    task automatic load(input int i0, input int i1);
        @(negedge clk);
        cfg_inc  = {AW'(i1), AW'(i0)};
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        $display("[TB] load inc0=%0d inc1=%0d", i0, i1);
    endtask

    initial begin
        int c0, c1, d0;

        cycles(3);
        chk_en = 1'b1;

        // Reset release, no load: silent, lock exactly LOCK edges later.
        en  = 2'b11;
        rst = 1'b0;
        count_ce(15, c0, c1, d0);
        check("locked_before_16", int'(locked), 0);
        check("busy_idle", int'(busy), 0);
        cycles(1);
        check("locked_at_16", int'(locked), 1);
        check("silent_ce_count", c0 + c1, 0);
        $display("[TB] reset release done");

        // First load: 128 / 64 from zero increments apply on the next edge.
        load(128, 64);
        check("busy_after_load", int'(busy), 1);
        check("locked_after_load", int'(locked), 0);
        cycles(1);
        check("busy_cleared", int'(busy), 0);
        cycles(15);
        check("relock_before", int'(locked), 0);
        cycles(1);
        check("relock_at_16", int'(locked), 1);
        count_ce(64, c0, c1, d0);
        check("ch0_inc128_per64", c0, 32);
        check("ch1_inc64_per64", c1, 16);

        // inc0 = 3: exactly 3 pulses in any 256-cycle window.
        load(3, 64);
        cycles(300);
        count_ce(256, c0, c1, d0);
        check("ch0_inc3_per256", c0, 3);
        check("ch1_inc64_per256", c1, 64);

        // Retune ch0 64 -> 128 mid-stream: no short or double pulse.
        load(64, 64);
        cycles(100);
        check("locked_before_retune", int'(locked), 1);
        load(128, 64);
        check("locked_drop_retune", int'(locked), 0);
        count_ce(40, c0, c1, d0);
        check("retune_no_double", d0, 0);
        check("retune_locked_again", int'(locked), 1);
        $display("[TB] retune done");

        // en[1] low for 10 cycles: ch1 silent, lock untouched.
        @(negedge clk);
        en = 2'b01;
        count_ce(10, c0, c1, d0);
        check("ch1_held_silent", c1, 0);
        check("ch0_running", c0, 5);
        check("locked_with_en_low", int'(locked), 1);
        en = 2'b11;
        count_ce(40, c0, c1, d0);
        check("ch1_resumed", c1, 10);
        $display("[TB] channel hold done");

        // Reset asserted mid-cycle while busy: outputs clear asynchronously.
        load(32, 16);
        check("busy_before_rst", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_ce", int'(ce), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_locked", int'(locked), 0);
        cycles(2);
        rst = 1'b0;
        count_ce(40, c0, c1, d0);
        check("post_rst_silent", c0 + c1, 0);
        check("post_rst_locked", int'(locked), 1);
        $display("[TB] reset pulse done");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
